logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one k-bit logic unit (AND/OR/XOR/pass) between four requesters. Each requester presents a 3-bit opcode and two operands. The block grants one requester at a time, captures its operands, and drives the unit's one-hot 8-way result select. It returns a registered result, tagged with the requester ID, over a valid/ready handshake. It sits between the instruction front-ends and the shared logic datapath.

---
 rtl/logic_unit_arbiter.sv | 153 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one k-bit AND/OR/XOR/pass unit among four requesters.
// Optional illegal-opcode flag port res_err is enabled by defining LOGIC_ARB_ERR_EN.
module logic_unit_arbiter #(
  parameter int k = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [11:0]    op,
  input  logic [4*k-1:0] a_in,
  input  logic [4*k-1:0] b_in,
  output logic [3:0]     grant,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [k-1:0]   res_data,
  output logic [1:0]     res_id
`ifdef LOGIC_ARB_ERR_EN
  ,
  output logic           res_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [1:0]     ptr_r;
  logic [2:0]     op_r;
  logic [k-1:0]   a_r;
  logic [k-1:0]   b_r;
  logic [1:0]     id_r;
  logic [2:0]     pick_s;
  logic           win_ok_s;
  logic [1:0]     win_s;
  logic [2:0]     op_a_s [4];
  logic [k-1:0]   a_a_s  [4];
  logic [k-1:0]   b_a_s  [4];
  logic [k-1:0]   src_s  [8];
  logic [7:0]     sel_s;
  logic [k-1:0]   mux_s;

  // First requesting index at or after p; upper bit flags that one was found.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx  = p + 2'(i);
      pick = r[idx] ? {1'b1, idx} : pick;
    end
    return pick;
  endfunction

  // Unpack the per-requester opcode and operand fields.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      op_a_s[i] = op[3*i +: 3];
      a_a_s[i]  = a_in[k*i +: k];
      b_a_s[i]  = b_in[k*i +: k];
    end
  end

  // Round-robin winner selection.
  always_comb begin
    pick_s   = rr_pick(req, ptr_r);
    win_ok_s = pick_s[2];
    win_s    = pick_s[1:0];
  end

  // One-hot result select; sources 5-7 stay zero so illegal opcodes yield zero.
  always_comb begin
    sel_s    = 8'b0000_0001 << op_r;
    src_s[0] = a_r & b_r;
    src_s[1] = a_r | b_r;
    src_s[2] = a_r ^ b_r;
    src_s[3] = a_r;
    src_s[4] = b_r;
    src_s[5] = {k{1'b0}};
    src_s[6] = {k{1'b0}};
    src_s[7] = {k{1'b0}};
    mux_s    = {k{1'b0}};
    for (int j = 0; j < 8; j++) begin
      mux_s = mux_s | ({k{sel_s[j]}} & src_s[j]);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_ok_s) state_s = EXEC;
        else          state_s = IDLE;
      end
      EXEC: state_s = HOLD;
      HOLD: begin
        if (res_ready) state_s = IDLE;
        else           state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Capture, grant pulse, pointer update and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= 2'd0;
      grant     <= 4'b0000;
      op_r      <= 3'b000;
      a_r       <= {k{1'b0}};
      b_r       <= {k{1'b0}};
      id_r      <= 2'd0;
      res_valid <= 1'b0;
      res_data  <= {k{1'b0}};
      res_id    <= 2'd0;
`ifdef LOGIC_ARB_ERR_EN
      res_err   <= 1'b0;
`endif
    end else begin
      grant <= 4'b0000;
      if (state_r == IDLE && win_ok_s) begin
        grant <= 4'b0001 << win_s;
        op_r  <= op_a_s[win_s];
        a_r   <= a_a_s[win_s];
        b_r   <= b_a_s[win_s];
        id_r  <= win_s;
        ptr_r <= win_s + 2'd1;
      end
      if (state_r == EXEC) begin
        res_valid <= 1'b1;
        res_data  <= mux_s;
        res_id    <= id_r;
`ifdef LOGIC_ARB_ERR_EN
        res_err   <= (op_r > 3'd4);
`endif
      end
      if (state_r == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized
// transactions checked against a rule-level reference model (round-robin pointer, op table).
module tb_logic_unit_arbiter;

`ifdef LOGIC_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        res_ready = 1'b0;
  logic [2:0]  opv [4];
  logic [7:0]  av  [4];
  logic [7:0]  bv  [4];
  logic [11:0] op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  grant;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_err_obs;

  int vectors = 0;
  int errors  = 0;
  int mptr    = 0;

  assign op   = {opv[3], opv[2], opv[1], opv[0]};
  assign a_in = {av[3], av[2], av[1], av[0]};
  assign b_in = {bv[3], bv[2], bv[1], bv[0]};

  logic_unit_arbiter #(.k(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
    .grant(grant), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
`ifdef LOGIC_ARB_ERR_EN
    , .res_err(res_err_obs)
`endif
  );

`ifndef LOGIC_ARB_ERR_EN
  assign res_err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_res(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return x;
      3'd4:    return y;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] o);
    return ERR_EN && (o >= 3'd5);
  endfunction

  function automatic int ref_winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; res_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({grant, res_valid, res_data, res_id, res_err_obs} !== {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got g=%b v=%b d=%h id=%0d e=%b want all zero",
               grant, res_valid, res_data, res_id, res_err_obs);
    end
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single_op();
    req = 4'b0001; opv[0] = 3'd0; av[0] = 8'hF0; bv[0] = 8'h3C; res_ready = 1'b1;
    tick();
    vectors++;
    if ({grant, res_valid} !== {4'b0001, 1'b0}) begin
      errors++; $display("FAIL single_grant: got g=%b v=%b want g=0001 v=0", grant, res_valid);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({grant, res_valid, res_data, res_id} !== {4'b0000, 1'b1, 8'h30, 2'd0}) begin
      errors++; $display("FAIL single_result: got g=%b v=%b d=%h id=%0d want g=0000 v=1 d=30 id=0",
                         grant, res_valid, res_data, res_id);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL single_handshake: got v=%b want 0", res_valid);
    end
    mptr = 1;
  endtask

  task automatic test_all_opcodes();
    logic [2:0] ops [6];
    logic [7:0] exp [6];
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    exp = '{8'h05, 8'hAF, 8'hAA, 8'hA5, 8'h0F, 8'h00};
    for (int i = 0; i < 6; i++) begin
      req = 4'b0100; opv[2] = ops[i]; av[2] = 8'hA5; bv[2] = 8'h0F; res_ready = 1'b1;
      tick();
      vectors++;
      if (grant !== 4'b0100) begin
        errors++; $display("FAIL opcode_grant op=%0d: got %b want 0100", ops[i], grant);
      end
      req = 4'b0000;
      tick();
      vectors++;
      if ({res_valid, res_data, res_id, res_err_obs} !== {1'b1, exp[i], 2'd2, ref_err(ops[i])}) begin
        errors++; $display("FAIL opcode_result op=%0d: got v=%b d=%h id=%0d e=%b want v=1 d=%h id=2 e=%b",
                           ops[i], res_valid, res_data, res_id, res_err_obs, exp[i], ref_err(ops[i]));
      end
      tick();
    end
    mptr = 3;
  endtask

  task automatic test_round_robin();
    int w;
    rst = 1'b1; tick(); rst = 1'b0; mptr = 0;
    for (int i = 0; i < 4; i++) begin
      opv[i] = 3'($urandom_range(0, 4)); av[i] = 8'($urandom); bv[i] = 8'($urandom);
    end
    req = 4'b1111; res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      w = ref_winner(req, mptr);
      tick();
      vectors++;
      if (grant !== (4'b0001 << w)) begin
        errors++; $display("FAIL rr_grant #%0d: got %b want %b", n, grant, 4'b0001 << w);
      end
      tick();
      vectors++;
      if ({grant, res_valid, res_data, res_id} !== {4'b0000, 1'b1, ref_res(opv[w], av[w], bv[w]), 2'(w)}) begin
        errors++; $display("FAIL rr_result #%0d: got g=%b v=%b d=%h id=%0d want g=0000 v=1 d=%h id=%0d",
                           n, grant, res_valid, res_data, res_id, ref_res(opv[w], av[w], bv[w]), w);
      end
      tick();
      vectors++;
      if ({grant, res_valid} !== {4'b0000, 1'b0}) begin
        errors++; $display("FAIL rr_gap #%0d: got g=%b v=%b want g=0000 v=0", n, grant, res_valid);
      end
      mptr = (w + 1) % 4;
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    int w;
    req = 4'b0001; opv[0] = 3'd2; av[0] = 8'h5A; bv[0] = 8'hFF; res_ready = 1'b0;
    w = ref_winner(req, mptr);
    exp_d = ref_res(opv[0], av[0], bv[0]);
    tick();
    vectors++;
    if (grant !== (4'b0001 << w)) begin
      errors++; $display("FAIL bp_grant: got %b want %b", grant, 4'b0001 << w);
    end
    mptr = (w + 1) % 4;
    req = 4'b0110; opv[1] = 3'd1; av[1] = 8'h81; bv[1] = 8'h18; opv[2] = 3'd0;
    tick();
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if ({grant, res_valid, res_data, res_id} !== {4'b0000, 1'b1, exp_d, 2'd0}) begin
        errors++; $display("FAIL bp_hold c=%0d: got g=%b v=%b d=%h id=%0d want g=0000 v=1 d=%h id=0",
                           c, grant, res_valid, res_data, res_id, exp_d);
      end
      if (c < 5) tick();
    end
    res_ready = 1'b1;
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got v=%b want 0", res_valid);
    end
    w = ref_winner(req, mptr);
    tick();
    vectors++;
    if (grant !== 4'b0010 || w != 1) begin
      errors++; $display("FAIL bp_next_grant: got %b want 0010 (model winner %0d)", grant, w);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, ref_res(opv[1], av[1], bv[1]), 2'd1}) begin
      errors++; $display("FAIL bp_next_result: got v=%b d=%h id=%0d want v=1 d=%h id=1",
                         res_valid, res_data, res_id, ref_res(opv[1], av[1], bv[1]));
    end
    tick();
    mptr = 2;
  endtask

  task automatic test_reset_mid_op();
    req = 4'b0100; opv[2] = 3'd1; av[2] = 8'h12; bv[2] = 8'h34; res_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_hold: got v=%b want 1", res_valid);
    end
    rst = 1'b1; req = 4'b1001;
    opv[0] = 3'd3; av[0] = 8'h77; bv[0] = 8'h00; opv[3] = 3'd4; av[3] = 8'h00; bv[3] = 8'h99;
    tick();
    vectors++;
    if ({grant, res_valid, res_data, res_id} !== {4'b0000, 1'b0, 8'h00, 2'd0}) begin
      errors++; $display("FAIL rmid_reset: got g=%b v=%b d=%h id=%0d want all zero",
                         grant, res_valid, res_data, res_id);
    end
    rst = 1'b0; mptr = 0;
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL rmid_first_grant: got %b want 0001", grant);
    end
    req = 4'b0000; res_ready = 1'b1;
    tick();
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, 8'h77, 2'd0}) begin
      errors++; $display("FAIL rmid_result: got v=%b d=%h id=%0d want v=1 d=77 id=0",
                         res_valid, res_data, res_id);
    end
    tick();
    mptr = 1;
  endtask

  task automatic test_drop_after_grant();
    req = 4'b1000; opv[3] = 3'd3; av[3] = 8'h11; bv[3] = 8'h22; res_ready = 1'b1;
    tick();
    vectors++;
    if (grant !== 4'b1000) begin
      errors++; $display("FAIL drop_grant: got %b want 1000", grant);
    end
    req = 4'b0000; av[3] = 8'hEE;
    tick();
    vectors++;
    if ({res_valid, res_data, res_id} !== {1'b1, 8'h11, 2'd3}) begin
      errors++; $display("FAIL drop_result: got v=%b d=%h id=%0d want v=1 d=11 id=3",
                         res_valid, res_data, res_id);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (grant !== 4'b0000) begin
        errors++; $display("FAIL drop_no_regrant c=%0d: got %b want 0000", c, grant);
      end
    end
    mptr = 0;
  endtask

  task automatic test_random();
    int w;
    int d;
    logic [7:0] exp_d;
    logic exp_e;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        opv[i] = 3'($urandom_range(0, 7)); av[i] = 8'($urandom); bv[i] = 8'($urandom);
      end
      req = 4'($urandom_range(1, 15));
      d = $urandom_range(0, 3);
      w = ref_winner(req, mptr);
      exp_d = ref_res(opv[w], av[w], bv[w]);
      exp_e = ref_err(opv[w]);
      tick();
      vectors++;
      if (grant !== (4'b0001 << w)) begin
        errors++; $display("FAIL rand_grant #%0d: got %b want %b (req=%b)", n, grant, 4'b0001 << w, req);
      end
      mptr = (w + 1) % 4;
      req = 4'($urandom); res_ready = 1'b0;
      for (int i = 0; i < 4; i++) av[i] = 8'($urandom);
      tick();
      for (int c = 0; c <= d; c++) begin
        vectors++;
        if ({grant, res_valid, res_data, res_id, res_err_obs} !== {4'b0000, 1'b1, exp_d, 2'(w), exp_e}) begin
          errors++; $display("FAIL rand_result #%0d c=%0d: got g=%b v=%b d=%h id=%0d e=%b want g=0000 v=1 d=%h id=%0d e=%b",
                             n, c, grant, res_valid, res_data, res_id, res_err_obs, exp_d, w, exp_e);
        end
        if (c < d) tick();
      end
      res_ready = 1'b1;
      tick();
      vectors++;
      if ({grant, res_valid} !== {4'b0000, 1'b0}) begin
        errors++; $display("FAIL rand_handshake #%0d: got g=%b v=%b want g=0000 v=0", n, grant, res_valid);
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      opv[i] = 3'd0; av[i] = 8'h00; bv[i] = 8'h00;
    end
    test_reset();
    test_single_op();
    test_all_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_drop_after_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
